// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and fetch FSM state type for the fetch stage
package cpu_pkg;
    localparam int PC_W_DEFAULT = 16;
    localparam int INSTR_W_DEFAULT = 16;
    localparam logic [INSTR_W_DEFAULT-1:0] NOP_INSTR = '0;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/pipeline_fetch_stage_if.sv
// pipeline_fetch_stage_if: instruction-memory req/ack bus between fetch stage and imem
interface pipeline_fetch_stage_if #(
    parameter int PC_W = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_adr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    modport master(output imem_req, imem_adr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_adr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pipeline_fetch_registers.sv
// pipeline_fetch_registers: IF/ID register; reset > branch > flush > stall > load > bubble
module pipeline_fetch_registers
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_branch,
    input  logic               i_flush,
    input  logic               i_stall,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_valid
);
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;
    always_ff @(posedge i_clock) begin
        if (i_reset || i_branch || i_flush || (!i_stall && !i_load)) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/pipeline_fetch_stage.sv
// pipeline_fetch_stage: PC, imem req/ack FSM, skid buffer and IF/ID register.
// FETCH_PERF_CNT_EN enables the saturating stall-cycle counter; otherwise it reads 0.
module pipeline_fetch_stage
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_stall_d,
    input  logic                   i_flush_d,
    input  logic                   i_branch_taken_e,
    input  logic [PC_W-1:0]        i_branch_target_e,
    pipeline_fetch_stage_if.master imem,
    output logic [INSTR_W-1:0]     o_instr_d,
    output logic [PC_W-1:0]        o_pc_d,
    output logic                   o_valid_d,
    output logic [15:0]            o_stall_cycles
);
    fetch_state_t       r_state, w_next_state;
    logic [PC_W-1:0]    r_pc_f, w_pc_next;
    logic [INSTR_W-1:0] r_skid, w_load_instr;
    logic               w_load, w_skid_load;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pc_f  <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc_f  <= w_pc_next;
        end
    end
    always_ff @(posedge i_clock)
        if (w_skid_load) r_skid <= imem.imem_rdata;
    // A branch always wins; an ack is only consumed in WAIT (stale acks in DISCARD are dropped)
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc_f;
        w_load       = 1'b0;
        w_load_instr = imem.imem_rdata;
        w_skid_load  = 1'b0;
        case (r_state)
            IDLE: w_next_state = WAIT;
            WAIT: begin
                if (i_branch_taken_e) begin
                    w_pc_next    = i_branch_target_e;
                    w_next_state = imem.imem_ack ? WAIT : DISCARD;
                end else if (imem.imem_ack && i_stall_d) begin
                    w_skid_load  = 1'b1;
                    w_next_state = HOLD;
                end else if (imem.imem_ack) begin
                    w_load    = 1'b1;
                    w_pc_next = r_pc_f + PC_W'(1);
                end
            end
            HOLD: begin
                if (i_branch_taken_e) begin
                    w_pc_next    = i_branch_target_e;
                    w_next_state = WAIT;
                end else if (!i_stall_d) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid;
                    w_pc_next    = r_pc_f + PC_W'(1);
                    w_next_state = WAIT;
                end
            end
            DISCARD: begin
                w_pc_next    = i_branch_taken_e ? i_branch_target_e : r_pc_f;
                w_next_state = imem.imem_ack ? WAIT : DISCARD;
            end
            default: w_next_state = IDLE;
        endcase
    end
    assign imem.imem_req = (r_state == WAIT);
    assign imem.imem_adr = r_pc_f;
    pipeline_fetch_registers #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if_id (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_branch(i_branch_taken_e),
        .i_flush (i_flush_d),
        .i_stall (i_stall_d),
        .i_load  (w_load),
        .i_instr (w_load_instr),
        .i_pc    (r_pc_f),
        .o_instr (o_instr_d),
        .o_pc    (o_pc_d),
        .o_valid (o_valid_d)
    );
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_stall_cycles <= '0;
        else if ((i_stall_d || (r_state == WAIT && !imem.imem_ack)) && r_stall_cycles != 16'hFFFF)
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end
    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// tb_pipeline_fetch_stage: directed vector table, corner sequences, and a randomized run
// checked against an instruction-stream model with a tagged-data memory responder.
module tb_pipeline_fetch_stage;
    import cpu_pkg::*;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_d = 1'b0, flush_d = 1'b0, branch_taken_e = 1'b0;
    logic [15:0] branch_target_e = '0;
    logic [15:0] instr_d, pc_d, stall_cycles;
    logic        valid_d;
    int          n_checks = 0, n_fail = 0;

    pipeline_fetch_stage_if #(.PC_W(16), .INSTR_W(16)) imem ();

    pipeline_fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_stall_d        (stall_d),
        .i_flush_d        (flush_d),
        .i_branch_taken_e (branch_taken_e),
        .i_branch_target_e(branch_target_e),
        .imem             (imem),
        .o_instr_d        (instr_d),
        .o_pc_d           (pc_d),
        .o_valid_d        (valid_d),
        .o_stall_cycles   (stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  sfb;
        logic [15:0] tg;
        logic        ak;
        logic [15:0] rd;
        logic        rq;
        logic [15:0] ad;
        logic        vd;
        logic [15:0] ins;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t v(input logic [2:0] sfb, input logic [15:0] tg, input logic ak,
                               input logic [15:0] rd, input logic rq, input logic [15:0] ad,
                               input logic vd, input logic [15:0] ins, input logic [15:0] pc);
        vec_t r;
        r.sfb = sfb; r.tg = tg; r.ak = ak; r.rd = rd;
        r.rq = rq; r.ad = ad; r.vd = vd; r.ins = ins; r.pc = pc;
        return r;
    endfunction

    function automatic logic [15:0] tag(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // random-phase state
    logic [15:0] exp_next, mem_adr, model_cnt, prev_instr, prev_pc;
    logic        mem_out, prev_hold, prev_br, prev_valid;
    int          mem_wait, idle;

    initial begin
        // inputs {stall,flush,branch}, target, ack, rdata | expected req, adr, valid, instr, pc
        tbl[0]  = v(3'b000, 16'h0000, 1'b1, 16'hEEEE, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[1]  = v(3'b000, 16'h0000, 1'b1, 16'h1000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[2]  = v(3'b000, 16'h0000, 1'b1, 16'h1001, 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0000);
        tbl[3]  = v(3'b000, 16'h0000, 1'b1, 16'h1002, 1'b1, 16'h0002, 1'b1, 16'h1001, 16'h0001);
        tbl[4]  = v(3'b000, 16'h0000, 1'b1, 16'h1003, 1'b1, 16'h0003, 1'b1, 16'h1002, 16'h0002);
        tbl[5]  = v(3'b100, 16'h0000, 1'b1, 16'h2004, 1'b1, 16'h0004, 1'b1, 16'h1003, 16'h0003);
        tbl[6]  = v(3'b100, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 16'h0004, 1'b1, 16'h1003, 16'h0003);
        tbl[7]  = v(3'b100, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1003, 16'h0003);
        tbl[8]  = v(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1003, 16'h0003);
        tbl[9]  = v(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h2004, 16'h0004);
        tbl[10] = v(3'b001, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000);
        tbl[11] = v(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        tbl[12] = v(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        tbl[13] = v(3'b000, 16'h0000, 1'b1, 16'hBAD5, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        tbl[14] = v(3'b000, 16'h0000, 1'b1, 16'h3040, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        tbl[15] = v(3'b111, 16'h1234, 1'b1, 16'h3041, 1'b1, 16'h0041, 1'b1, 16'h3040, 16'h0040);
        tbl[16] = v(3'b001, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000);
        tbl[17] = v(3'b000, 16'h0000, 1'b1, 16'h4FFF, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000);
        tbl[18] = v(3'b000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h4FFF, 16'hFFFF);

        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            chk($sformatf("row%0d_req", i), 16'(imem.imem_req), 16'(tbl[i].rq));
            chk($sformatf("row%0d_adr", i), imem.imem_adr, tbl[i].ad);
            chk($sformatf("row%0d_valid", i), 16'(valid_d), 16'(tbl[i].vd));
            chk($sformatf("row%0d_instr", i), instr_d, tbl[i].ins);
            chk($sformatf("row%0d_pc", i), pc_d, tbl[i].pc);
            {stall_d, flush_d, branch_taken_e} = tbl[i].sfb;
            branch_target_e = tbl[i].tg;
            imem.imem_ack = tbl[i].ak;
            imem.imem_rdata = tbl[i].rd;
            @(posedge clock); #1;
        end

        // reset asserted mid-WAIT
        chk("pre_reset_req", 16'(imem.imem_req), 16'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_req", 16'(imem.imem_req), 16'd0);
        chk("rst_adr", imem.imem_adr, 16'h0000);
        chk("rst_valid", 16'(valid_d), 16'd0);
        chk("rst_instr", instr_d, 16'h0000);
        chk("rst_pc", pc_d, 16'h0000);
        chk("rst_perf", stall_cycles, 16'h0000);
        reset = 1'b0;

        // five stall cycles, fetched word parked in the skid buffer meanwhile
        stall_d = 1'b1;
        for (int c = 0; c < 5; c++) begin
            imem.imem_ack = (c == 1);
            imem.imem_rdata = 16'h7777;
            @(posedge clock); #1;
        end
        imem.imem_ack = 1'b0;
        stall_d = 1'b0;
        chk("perf_5_stalls", stall_cycles, PERF_ON ? 16'd5 : 16'd0);
        chk("hold_req_low", 16'(imem.imem_req), 16'd0);
        @(posedge clock); #1;
        chk("skid_valid", 16'(valid_d), 16'd1);
        chk("skid_instr", instr_d, 16'h7777);
        chk("skid_pc", pc_d, 16'h0000);
        chk("skid_next_adr", imem.imem_adr, 16'h0001);

        // randomized run against the instruction-stream model
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        mem_out = 1'b0; mem_wait = 0; mem_adr = '0;
        exp_next = 16'h0000; model_cnt = '0; idle = 0;
        prev_hold = 1'b0; prev_br = 1'b0; prev_valid = 1'b0; prev_instr = '0; prev_pc = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_hold) begin
                chk("rnd_hold_valid", 16'(valid_d), 16'(prev_valid));
                chk("rnd_hold_instr", instr_d, prev_instr);
                chk("rnd_hold_pc", pc_d, prev_pc);
            end
            if (prev_br) chk("rnd_branch_bubble", 16'(valid_d), 16'd0);
            if (valid_d) chk("rnd_instr_tag", instr_d, tag(pc_d));
            chk("rnd_perf", stall_cycles, PERF_ON ? model_cnt : 16'd0);
            // memory: accepts one request, answers 0..3 cycles later with address-tagged data
            imem.imem_ack = 1'b0;
            if (imem.imem_req && !mem_out) begin
                mem_out = 1'b1;
                mem_adr = imem.imem_adr;
                mem_wait = int'($urandom_range(0, 3));
            end else if (imem.imem_req && mem_out) begin
                chk("rnd_adr_stable", imem.imem_adr, mem_adr);
            end
            if (mem_out) begin
                if (mem_wait == 0) begin
                    imem.imem_ack = 1'b1;
                    imem.imem_rdata = tag(mem_adr);
                    mem_out = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            stall_d = ($urandom_range(0, 3) == 0);
            branch_taken_e = ($urandom_range(0, 24) == 0);
            flush_d = branch_taken_e && ($urandom_range(0, 1) == 1);
            branch_target_e = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                                          : 16'($urandom);
            if (branch_taken_e) begin
                exp_next = branch_target_e;
            end else if (valid_d && !stall_d) begin
                chk("rnd_seq_pc", pc_d, exp_next);
                exp_next = pc_d + 16'd1;
                idle = 0;
            end
            if (stall_d || (imem.imem_req && !imem.imem_ack))
                model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
            prev_hold = stall_d && !branch_taken_e;
            prev_br = branch_taken_e;
            prev_valid = valid_d;
            prev_instr = instr_d;
            prev_pc = pc_d;
            idle++;
            if (idle > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL rnd_progress: no instruction delivered for %0d cycles", idle);
                break;
            end
            @(posedge clock); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
